// File: rtl/smart_ram.sv
// -----------------------------------------------------------------------------
// smart_ram
//   Circular delay-line memory for an audio effect engine. Every cycle with
//   sample_valid high appends one sample at the write pointer. The effect
//   engine asks for a sample by age: offset 0 is the newest sample. The answer
//   appears two cycles after the request, together with a one-cycle
//   sram_read_finish pulse.
//
//   A read returns the memory as it stood in the request cycle, before any
//   write made in that same cycle. So offset 2^ADDR_WIDTH-1 still returns the
//   oldest sample even while that slot is being overwritten.
//
// Configuration macro:
//   SMART_RAM_CLEAR_EN - when defined, every reset is followed by a CLEAR
//                        sweep. The sweep zeroes all 2^ADDR_WIDTH words, one
//                        word per cycle. During the sweep, ready is low and
//                        writes and read requests are ignored. When the macro
//                        is undefined, the memory contents after reset are
//                        unspecified.
//
// Parameters:
//   DATA_WIDTH       sample width
//   ADDR_WIDTH       log2 of the delay-line depth
//
// Ports:
//   clk              single clock, rising edge
//   rst              synchronous active-high reset
//   sample_valid     write strobe, one sample per high cycle
//   sample_in        sample written when sample_valid is high
//   sram_rd          read request, accepted only while ready is high
//   sram_offset      age of the requested sample (0 = newest)
//   sram_data_out    read data, held until the next completed read
//   sram_read_finish one-cycle pulse marking valid sram_data_out
//   ready            high when a new sram_rd will be accepted
// -----------------------------------------------------------------------------
module smart_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sram_rd,
  input  logic [ADDR_WIDTH-1:0] sram_offset,
  output logic [DATA_WIDTH-1:0] sram_data_out,
  output logic                  sram_read_finish,
  output logic                  ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef SMART_RAM_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE, S_READ, S_FINISH, S_CLEAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_READ, S_FINISH} state_t;
`endif

  state_t                r_state;
  state_t                w_next;

  logic [ADDR_WIDTH-1:0] r_wp;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_p0;
  logic [DATA_WIDTH-1:0] r_dout_p1;

  logic                  w_accept;
  logic                  w_wr_en;
  logic                  w_clearing;
  logic [ADDR_WIDTH-1:0] w_raddr;

  // The newest sample sits one slot behind the write pointer. The modular
  // wrap comes from the fixed ADDR_WIDTH arithmetic.
  function automatic logic [ADDR_WIDTH-1:0] age_to_addr(
    input logic [ADDR_WIDTH-1:0] wp,
    input logic [ADDR_WIDTH-1:0] age
  );
    return wp - ADDR_WIDTH'(1) - age;
  endfunction

  assign w_raddr = age_to_addr(r_wp, sram_offset);

`ifdef SMART_RAM_CLEAR_EN
  logic [ADDR_WIDTH-1:0] r_clr;

  assign w_clearing = (r_state == S_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr <= '0;
    end else if (w_clearing) begin
      r_clr <= r_clr + ADDR_WIDTH'(1);
    end
  end
`else
  assign w_clearing = 1'b0;
`endif

  // Writes never stall on read activity. Reset and the clear sweep are the
  // only things that drop a sample.
  assign w_wr_en = sample_valid && !w_clearing && !rst;

  // Next state and output decode
  always_comb begin
    w_next           = r_state;
    w_accept         = 1'b0;
    ready            = 1'b0;
    sram_read_finish = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (sram_rd) begin
          w_accept = 1'b1;
          w_next   = S_READ;
        end
      end
      S_READ: begin
        w_next = S_FINISH;
      end
      S_FINISH: begin
        sram_read_finish = 1'b1;
        w_next           = S_IDLE;
      end
`ifdef SMART_RAM_CLEAR_EN
      S_CLEAR: begin
        if (r_clr == ADDR_WIDTH'(DEPTH - 1)) begin
          w_next = S_IDLE;
        end
      end
`endif
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Control registers. Reset also aborts any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef SMART_RAM_CLEAR_EN
      r_state <= S_CLEAR;
`else
      r_state <= S_IDLE;
`endif
      r_wp <= '0;
    end else begin
      r_state <= w_next;
      if (w_wr_en) begin
        r_wp <= r_wp + ADDR_WIDTH'(1);
      end
    end
  end

  // ---- stage p0: request cycle. The array is read at the latched address.
  // The nonblocking write in the same cycle lands afterwards, which gives
  // read-before-write for the slot currently being overwritten.
  always_ff @(posedge clk) begin
`ifdef SMART_RAM_CLEAR_EN
    if (w_clearing) begin
      r_mem[r_clr] <= '0;
    end else if (w_wr_en) begin
      r_mem[r_wp] <= sample_in;
    end
`else
    if (w_wr_en) begin
      r_mem[r_wp] <= sample_in;
    end
`endif
    if (w_accept) begin
      r_rd_p0 <= r_mem[w_raddr];
    end
  end

  // ---- stage p1: READ cycle. Data moves to the output holding register and
  // becomes visible in FINISH. It then stays put until the next read
  // completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout_p1 <= '0;
    end else if (r_state == S_READ) begin
      r_dout_p1 <= r_rd_p0;
    end
  end

  assign sram_data_out = r_dout_p1;

endmodule

// File: tb/tb_smart_ram.sv
// -----------------------------------------------------------------------------
// tb_smart_ram
//   Self-checking bench for smart_ram with ADDR_WIDTH=4 and DATA_WIDTH=16.
//   The reference model is a plain history queue of every accepted sample. A
//   request at offset k expects the sample written k writes before the newest
//   one, as seen in the request cycle.
// -----------------------------------------------------------------------------
module tb_smart_ram;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic          sram_rd = 1'b0;
  logic [AW-1:0] sram_offset = '0;
  logic [DW-1:0] sram_data_out;
  logic          sram_read_finish;
  logic          ready;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] hist[$];

  smart_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .sample_valid    (sample_valid),
    .sample_in       (sample_in),
    .sram_rd         (sram_rd),
    .sram_offset     (sram_offset),
    .sram_data_out   (sram_data_out),
    .sram_read_finish(sram_read_finish),
    .ready           (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [DW-1:0] d);
    sample_valid = 1'b1;
    sample_in    = d;
    tick();
    hist.push_back(d);
    sample_valid = 1'b0;
  endtask

  // Reset for one cycle while random writes/reads are being driven; reset
  // must dominate them.
  task automatic do_reset();
    rst          = 1'b1;
    sample_valid = 1'($urandom);
    sample_in    = DW'($urandom);
    sram_rd      = 1'($urandom);
    tick();
    rst     = 1'b0;
    sram_rd = 1'b0;
    hist.delete();
`ifdef SMART_RAM_CLEAR_EN
    sample_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk("clear_ready_low", ready, 0);
      sample_in = DW'($urandom);
      sram_rd   = 1'($urandom);
      tick();
    end
    sample_valid = 1'b0;
    sram_rd      = 1'b0;
    for (int i = 0; i < N; i++) hist.push_back('0);
`else
    sample_valid = 1'b0;
`endif
    chk("rst_ready", ready, 1);
    chk("rst_finish", sram_read_finish, 0);
    chk("rst_data", sram_data_out, 0);
  endtask

  // One read transaction issued in cycle T. cw/cwd adds a write in cycle T.
  // busy_wr writes random samples during T+1 and T+2. hold2 keeps sram_rd
  // high in T+1, which must be ignored.
  task automatic do_read(input int off, input bit cw, input logic [DW-1:0] cwd,
                         input bit busy_wr, input bit hold2,
                         input bit use_const, input logic [DW-1:0] cexp,
                         input string tag);
    logic [DW-1:0] exp;
    bit            known;
    known = hist.size() > off;
    exp   = known ? hist[hist.size() - 1 - off] : '0;
    if (use_const) begin
      exp   = cexp;
      known = 1'b1;
    end
    chk({tag, "_ready_T"}, ready, 1);
    sram_rd      = 1'b1;
    sram_offset  = AW'(off);
    sample_valid = cw;
    sample_in    = cwd;
    tick();
    if (cw) hist.push_back(cwd);
    // T+1
    sram_rd      = hold2;
    sram_offset  = AW'($urandom);
    sample_valid = busy_wr;
    sample_in    = DW'($urandom);
    chk({tag, "_fin_T1"}, sram_read_finish, 0);
    chk({tag, "_ready_T1"}, ready, 0);
    tick();
    if (busy_wr) hist.push_back(sample_in);
    // T+2
    sram_rd      = 1'b0;
    sample_valid = busy_wr;
    sample_in    = DW'($urandom);
    chk({tag, "_fin_T2"}, sram_read_finish, 1);
    chk({tag, "_ready_T2"}, ready, 0);
    if (known) chk({tag, "_data_T2"}, sram_data_out, exp);
    tick();
    if (busy_wr) hist.push_back(sample_in);
    sample_valid = 1'b0;
    // T+3
    chk({tag, "_fin_T3"}, sram_read_finish, 0);
    chk({tag, "_ready_T3"}, ready, 1);
    if (known) chk({tag, "_data_hold"}, sram_data_out, exp);
  endtask

  initial begin
    tick();
    do_reset();

`ifdef SMART_RAM_CLEAR_EN
    do_read(3, 0, '0, 0, 0, 1, 16'h0000, "clear_zero");
    do_reset();
`endif

    // Five samples, newest and oldest of them
    for (int i = 1; i <= 5; i++) wr(DW'(i));
    do_read(0, 0, '0, 0, 0, 1, 16'd5, "five_off0");
    do_read(4, 0, '0, 0, 0, 1, 16'd1, "five_off4");

    // Wrap-around of the write pointer
    do_reset();
    for (int i = 1; i <= 20; i++) wr(DW'(i));
    do_read(0,  0, '0, 0, 0, 1, 16'd20, "wrap_off0");
    do_read(15, 0, '0, 0, 0, 1, 16'd5,  "wrap_off15");

    // Write coincident with the request: the old newest sample is returned
    wr(16'd3);
    do_read(0, 1, 16'd7, 0, 0, 1, 16'd3, "coinc_old");
    do_read(0, 0, '0,    0, 0, 1, 16'd7, "coinc_new");

    // Oldest slot overwritten in the request cycle: read-before-write
    do_read(15, 1, 16'hBEEF, 0, 0, 0, '0, "rbw_off15");
    do_read(0,  0, '0,       0, 0, 1, 16'hBEEF, "rbw_after");

    // A second request while busy is ignored
    do_read(2, 0, '0, 0, 1, 0, '0, "double_rd");
    tick();
    chk("double_rd_nofin_T4", sram_read_finish, 0);

    // Writes keep flowing during READ/FINISH
    do_read(1, 0, '0, 1, 0, 0, '0, "busy_wr");
    do_read(0, 0, '0, 0, 0, 0, '0, "busy_wr_newest");

    // Reset in the cycle after a request aborts it
    sram_rd     = 1'b1;
    sram_offset = '0;
    tick();
    sram_rd = 1'b0;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    hist.delete();
    chk("abort_nofin_T2", sram_read_finish, 0);
`ifdef SMART_RAM_CLEAR_EN
    chk("abort_ready_T2", ready, 0);
    for (int i = 0; i < N; i++) tick();
    for (int i = 0; i < N; i++) hist.push_back('0);
`else
    chk("abort_ready_T2", ready, 1);
`endif
    tick();
    chk("abort_nofin_T3", sram_read_finish, 0);
    chk("abort_data_zero", sram_data_out, 0);

    // Randomized traffic against the history model
    for (int i = 0; i < N; i++) wr(DW'($urandom));
    for (int it = 0; it < 150; it++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) wr(DW'($urandom));
      do_read($urandom_range(0, N - 1), 1'($urandom), DW'($urandom),
              1'($urandom), 1'($urandom), 0, '0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
